// File: rtl/temporal_encoder.sv
// Binary-to-time encoder: replays a captured vector of small values as spike
// times, one wire per channel, within a single gamma cycle. Each gamma cycle
// is preceded by a one-cycle clear pulse for downstream race logic.
module temporal_encoder #(
    parameter int NUM_CH            = 4,
    parameter int VAL_WIDTH         = 3,
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int PULSE_MODE        = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_CH*VAL_WIDTH-1:0]   in_data,
    output logic [NUM_CH-1:0]             spike,
    output logic                          gamma_rst,
    output logic                          gamma_done,
    output logic                          busy
);

    localparam int KW = (GAMMA_CYCLE_WIDTH > 1) ? $clog2(GAMMA_CYCLE_WIDTH) : 1;
    localparam logic [VAL_WIDTH-1:0] INF    = '1;
    localparam logic [KW-1:0]        K_LAST = KW'(GAMMA_CYCLE_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RESET,
        RUN
    } state_t;

    state_t                        state, state_nx;
    logic [KW-1:0]                 k, k_nx;
    logic [NUM_CH*VAL_WIDTH-1:0]   hold, hold_nx;
    logic                          hs;
    logic                          run_nx, last_nx;
    logic                          ready_nx, grst_nx, done_nx, busy_nx;
    logic [NUM_CH-1:0]             spike_nx;

    // Next state, cycle counter, hold register and registered-output values.
    // Outputs are derived from the upcoming state so they are all flop outputs.
    always_comb begin
        state_nx = state;
        k_nx     = k;
        hold_nx  = hold;
        hs       = in_valid && in_ready;

        case (state)
            IDLE: begin
                if (hs) begin
                    hold_nx  = in_data;
                    state_nx = RESET;
                end
            end
            RESET: begin
                k_nx     = '0;
                state_nx = RUN;
            end
            RUN: begin
                if (k == K_LAST) begin
                    if (hs) begin
                        hold_nx  = in_data;
                        state_nx = RESET;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    k_nx = k + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        run_nx   = (state_nx == RUN);
        last_nx  = run_nx && (k_nx == K_LAST);
        ready_nx = (state_nx == IDLE) || last_nx;
        grst_nx  = (state_nx == RESET);
        done_nx  = last_nx;
        busy_nx  = (state_nx != IDLE);

        spike_nx = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (run_nx && (hold[i*VAL_WIDTH +: VAL_WIDTH] != INF)) begin
                if (PULSE_MODE != 0) begin
                    spike_nx[i] = (32'(k_nx) >= 32'(hold[i*VAL_WIDTH +: VAL_WIDTH])) &&
                                  (32'(k_nx) <  32'(hold[i*VAL_WIDTH +: VAL_WIDTH]) + 32'(PULSE_WIDTH));
                end else begin
                    spike_nx[i] = (32'(k_nx) >= 32'(hold[i*VAL_WIDTH +: VAL_WIDTH]));
                end
            end
        end
    end

    // State, counter, hold and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            k          <= '0;
            hold       <= '0;
            in_ready   <= 1'b0;
            gamma_rst  <= 1'b0;
            gamma_done <= 1'b0;
            busy       <= 1'b0;
            spike      <= '0;
        end else begin
            state      <= state_nx;
            k          <= k_nx;
            hold       <= hold_nx;
            in_ready   <= ready_nx;
            gamma_rst  <= grst_nx;
            gamma_done <= done_nx;
            busy       <= busy_nx;
            spike      <= spike_nx;
        end
    end

endmodule

// File: tb/tb_temporal_encoder.sv
// Bench for temporal_encoder: a step-mode and a pulse-mode instance share
// stimulus; a phase-count reference model predicts every output each cycle.
module tb_temporal_encoder;

    localparam int NCH = 4;
    localparam int VW  = 3;
    localparam int G   = 16;
    localparam int PW  = 4;
    localparam int INF = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [NCH*VW-1:0] in_data;

    logic              rdy_s, grst_s, done_s, busy_s;
    logic [NCH-1:0]    spike_s;
    logic              rdy_p, grst_p, done_p, busy_p;
    logic [NCH-1:0]    spike_p;

    int pass_cnt = 0;
    int total    = 0;

    // reference model: phase -1 = idle, 0 = clear cycle, 1..G = run cycle k=phase-1
    int phase     = -1;
    int vals[NCH];
    bit after_rst = 1'b1;

    always #5 clk = ~clk;

    temporal_encoder #(
        .NUM_CH(NCH), .VAL_WIDTH(VW), .GAMMA_CYCLE_WIDTH(G),
        .PULSE_WIDTH(8), .PULSE_MODE(0)
    ) dut_step (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s),
        .in_data(in_data), .spike(spike_s), .gamma_rst(grst_s),
        .gamma_done(done_s), .busy(busy_s)
    );

    temporal_encoder #(
        .NUM_CH(NCH), .VAL_WIDTH(VW), .GAMMA_CYCLE_WIDTH(G),
        .PULSE_WIDTH(PW), .PULSE_MODE(1)
    ) dut_pulse (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_p),
        .in_data(in_data), .spike(spike_p), .gamma_rst(grst_p),
        .gamma_done(done_p), .busy(busy_p)
    );

    function automatic logic [NCH*VW-1:0] pack(int a3, int a2, int a1, int a0);
        return {VW'(a3), VW'(a2), VW'(a1), VW'(a0)};
    endfunction

    function automatic bit m_ready();
        return (phase == -1 && !after_rst) || (phase == G);
    endfunction

    function automatic logic [NCH-1:0] m_spike(bit pulse);
        logic [NCH-1:0] r = '0;
        int kk;
        if (phase >= 1) begin
            kk = phase - 1;
            for (int c = 0; c < NCH; c++)
                r[c] = (vals[c] != INF) && (kk >= vals[c]) && (!pulse || kk < vals[c] + PW);
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    // one clock: sample inputs, advance model at the edge, compare 1 time unit later
    task automatic step();
        bit              v_rst = rst;
        bit              v_val = in_valid;
        logic [NCH*VW-1:0] d   = in_data;
        bit              hs    = v_val && m_ready();
        @(posedge clk);
        if (!v_rst) begin
            phase = -1;
        end else if (phase == -1 || phase == G) begin
            if (hs) begin
                for (int c = 0; c < NCH; c++) vals[c] = int'(d[c*VW +: VW]);
                phase = 0;
            end else begin
                phase = -1;
            end
        end else begin
            phase++;
        end
        after_rst = !v_rst;
        #1;
        chk("in_ready",        32'(rdy_s),   32'(m_ready()));
        chk("gamma_rst",       32'(grst_s),  32'(phase == 0));
        chk("gamma_done",      32'(done_s),  32'(phase == G));
        chk("busy",            32'(busy_s),  32'(phase >= 0));
        chk("spike_step",      32'(spike_s), 32'(m_spike(1'b0)));
        chk("spike_pulse",     32'(spike_p), 32'(m_spike(1'b1)));
        chk("in_ready_pulse",  32'(rdy_p),   32'(m_ready()));
        chk("gamma_done_pulse",32'(done_p),  32'(phase == G));
    endtask

    task automatic send(logic [NCH*VW-1:0] v, int cycles);
        in_data  = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            in_data = NCH*VW'($urandom);
            step();
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0;
        step(); step();
        rst = 1'b1;
        step(); step();

        // basic step/pulse encoding with an infinite channel
        send(pack(3, 7, 0, 5), 20);

        // request during RUN is ignored until the preload slot; back-to-back cycles
        in_data = pack(2, 4, 6, 1); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        in_valid = 1'b1; in_data = pack(1, 1, 1, 1);
        repeat (12) step();
        in_valid = 1'b0;
        repeat (20) step();

        // pulse window, ties and extremes
        send(pack(7, 0, 5, 2), 19);
        send(pack(0, 0, 6, 6), 19);
        send(pack(6, 6, 0, 0), 19);
        send(pack(7, 7, 7, 7), 19);

        // reset mid-RUN with channel 3 already high
        in_data = pack(3, 7, 7, 7); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        chk("spike3_high_at_k6", 32'(spike_s[3]), 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        send(pack(4, 2, 7, 0), 20);

        // randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 79) != 0);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = NCH*VW'($urandom);
            step();
        end
        rst = 1'b1; in_valid = 1'b0;
        repeat (20) step();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
